// File: rtl/sipo_multich_controller.sv
// Sequencer for a serial ADC feeding a SIPO register: per channel it pulses the
// conversion strobe, skips lead bits, shifts the data word, then waits for an ack.
module sipo_multich_controller #(
  parameter int DATA_BITS   = 12,
  parameter int LEAD_BITS   = 3,
  parameter int NUM_CH      = 4,
  parameter int CONV_CYCLES = 2,
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1,
  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic           clk,
  input  logic           reset_b,
  input  logic           start,
  input  logic           continuous,
  input  logic           ready_ack,
  output logic           control_signal,
  output logic           data_logging,
  output logic [BW-1:0]  bit_index,
  output logic [CHW-1:0] ch_sel,
  output logic           data_ready,
  output logic           frame_done,
  output logic           busy
);

  localparam int MAXV_A = (CONV_CYCLES > LEAD_BITS) ? CONV_CYCLES : LEAD_BITS;
  localparam int MAXV   = (MAXV_A > DATA_BITS) ? MAXV_A : DATA_BITS;
  localparam int CW     = $clog2(MAXV + 1);

  localparam logic [CW-1:0]  CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0]  LEAD_LAST = CW'((LEAD_BITS > 0) ? LEAD_BITS - 1 : 0);
  localparam logic [CW-1:0]  DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CHW-1:0] LAST_CH   = CHW'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_SETTLE, S_SKIP, S_LOG, S_READY
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic           frame_done_q, frame_done_d;
  logic           control_q, logging_q, ready_q, busy_q;
  logic [BW-1:0]  bit_index_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    ch_d         = ch_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_CONV;
          ch_d    = '0;
        end
      end
      S_CONV: begin
        if (cnt_q == CONV_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        cnt_d   = '0;
        state_d = (LEAD_BITS == 0) ? S_LOG : S_SKIP;
      end
      S_SKIP: begin
        if (cnt_q == LEAD_LAST) begin
          state_d = S_LOG;
          cnt_d   = '0;
        end
      end
      S_LOG: begin
        if (cnt_q == DATA_LAST) begin
          state_d = S_READY;
          cnt_d   = '0;
        end
      end
      S_READY: begin
        cnt_d = '0;
        if (ready_ack) begin
          if (ch_q == LAST_CH) begin
            ch_d         = '0;
            frame_done_d = 1'b1;
            state_d      = continuous ? S_CONV : S_IDLE;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = S_CONV;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are decoded from the next state so the registered copies match a
  // Moore decode of state_q/cnt_q cycle for cycle, without output glitches.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ch_q         <= '0;
      frame_done_q <= 1'b0;
      control_q    <= 1'b0;
      logging_q    <= 1'b0;
      bit_index_q  <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      frame_done_q <= frame_done_d;
      control_q    <= (state_d == S_CONV);
      logging_q    <= (state_d == S_LOG);
      bit_index_q  <= (state_d == S_LOG) ? cnt_d[BW-1:0] : '0;
      ready_q      <= (state_d == S_READY);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign control_signal = control_q;
  assign data_logging   = logging_q;
  assign bit_index      = bit_index_q;
  assign ch_sel         = ch_q;
  assign data_ready     = ready_q;
  assign frame_done     = frame_done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_sipo_multich_controller.sv
// Directed checks of the SIPO channel sequencer: default 12/3/4/2 instance plus
// a minimal 1-bit/0-lead/1-channel instance.
module tb_sipo_multich_controller;

  logic       clk = 1'b0;
  logic       reset_b, start, continuous, ready_ack;
  logic       control_signal, data_logging, data_ready, frame_done, busy;
  logic [3:0] bit_index;
  logic [1:0] ch_sel;

  logic       start_s, cont_s, ack_s;
  logic       ctrl_s, log_s, ready_s, fd_s, busy_s;
  logic [0:0] bidx_s, ch_s;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  sipo_multich_controller #(
    .DATA_BITS(12), .LEAD_BITS(3), .NUM_CH(4), .CONV_CYCLES(2)
  ) u_dut (
    .clk(clk), .reset_b(reset_b), .start(start), .continuous(continuous),
    .ready_ack(ready_ack), .control_signal(control_signal),
    .data_logging(data_logging), .bit_index(bit_index), .ch_sel(ch_sel),
    .data_ready(data_ready), .frame_done(frame_done), .busy(busy)
  );

  sipo_multich_controller #(
    .DATA_BITS(1), .LEAD_BITS(0), .NUM_CH(1), .CONV_CYCLES(2)
  ) u_small (
    .clk(clk), .reset_b(reset_b), .start(start_s), .continuous(cont_s),
    .ready_ack(ack_s), .control_signal(ctrl_s),
    .data_logging(log_s), .bit_index(bidx_s), .ch_sel(ch_s),
    .data_ready(ready_s), .frame_done(fd_s), .busy(busy_s)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic ack_word();
    $display("ack  ch_sel=%0d t=%0t", ch_sel, $time);
    ready_ack = 1'b1;
    step();
    ready_ack = 1'b0;
  endtask

  // Steps until data_ready, bounded; n returns cycles waited.
  task automatic wait_ready(output int n);
    n = 0;
    while (!data_ready && n < 100) begin
      step();
      n++;
    end
    check_val("wait_ready", data_ready, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_ctrl"}, control_signal, 1'b0);
    check_val({tag, "_log"},  data_logging, 1'b0);
    check_val({tag, "_bidx"}, bit_index, 4'd0);
    check_val({tag, "_ch"},   ch_sel, 2'd0);
    check_val({tag, "_rdy"},  data_ready, 1'b0);
    check_val({tag, "_fd"},   frame_done, 1'b0);
    check_val({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    reset_b = 1'b1; start = 1'b0; continuous = 1'b0; ready_ack = 1'b0;
    start_s = 1'b0; cont_s = 1'b0; ack_s = 1'b0;
    #1 reset_b = 1'b0;
    #1;
    check_idle_outputs("rst");
    step();
    reset_b = 1'b1;
    repeat (3) step();
    check_val("no_auto_start", busy, 1'b0);

    // Single channel timing; start sampled at edge 0.
    start = 1'b1;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      step();
      start = 1'b0;
      $display("cyc %0d ctrl=%0b log=%0b bidx=%0d rdy=%0b", cyc, control_signal,
               data_logging, bit_index, data_ready);
      check_val($sformatf("t1_ctrl_%0d", cyc), control_signal, (cyc >= 1 && cyc <= 2));
      check_val($sformatf("t1_log_%0d", cyc), data_logging, (cyc >= 7 && cyc <= 18));
      check_val($sformatf("t1_bidx_%0d", cyc), bit_index,
                (cyc >= 7 && cyc <= 18) ? 32'(cyc - 7) : 32'd0);
      check_val($sformatf("t1_rdy_%0d", cyc), data_ready, (cyc >= 19));
      check_val($sformatf("t1_busy_%0d", cyc), busy, 1'b1);
    end

    // Withhold ack for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("hold_rdy", data_ready, 1'b1);
      check_val("hold_ch", ch_sel, 2'd0);
    end
    ack_word();
    check_val("ack0_rdy", data_ready, 1'b0);
    check_val("ack0_ch", ch_sel, 2'd1);
    check_val("ack0_ctrl", control_signal, 1'b1);
    check_val("ack0_fd", frame_done, 1'b0);

    // Remaining channels of the frame, immediate acks.
    for (int c = 1; c <= 3; c++) begin
      wait_ready(n);
      check_val($sformatf("lat_ch%0d", c), n, 32'd18);
      check_val($sformatf("frame_ch%0d", c), ch_sel, 32'(c));
      ack_word();
      if (c < 3) check_val($sformatf("fd_low_ch%0d", c), frame_done, 1'b0);
    end
    check_val("end_fd", frame_done, 1'b1);
    check_val("end_busy", busy, 1'b0);
    check_val("end_ch", ch_sel, 2'd0);
    step();
    check_val("end_fd_pulse", frame_done, 1'b0);
    check_val("end_stay_idle", busy, 1'b0);

    // Continuous mode: wrap straight into CONV.
    continuous = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      wait_ready(n);
      check_val($sformatf("cont_ch%0d", c), ch_sel, 32'(c));
      ack_word();
    end
    check_val("cont_fd", frame_done, 1'b1);
    check_val("cont_busy", busy, 1'b1);
    check_val("cont_ctrl", control_signal, 1'b1);
    check_val("cont_ch_wrap", ch_sel, 2'd0);

    // Stray start/ack while busy; drop continuous mid-frame.
    start = 1'b1; ready_ack = 1'b1;
    step();
    start = 1'b0; ready_ack = 1'b0;
    continuous = 1'b0;
    wait_ready(n);
    check_val("stray_lat", n, 32'd17);
    check_val("stray_ch", ch_sel, 2'd0);
    step();
    check_val("ack_not_remembered", data_ready, 1'b1);
    for (int c = 0; c <= 3; c++) begin
      wait_ready(n);
      check_val($sformatf("f2_ch%0d", c), ch_sel, 32'(c));
      ack_word();
    end
    check_val("f2_fd", frame_done, 1'b1);
    check_val("f2_busy", busy, 1'b0);

    // Asynchronous reset in the middle of LOG.
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(data_logging && bit_index == 4'd5) && n < 40) begin
      step();
      n++;
    end
    check_val("reach_bidx5", bit_index, 4'd5);
    reset_b = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    step();
    reset_b = 1'b1;
    repeat (3) step();
    check_val("post_rst_idle", busy, 1'b0);

    // Minimal parameter set: SETTLE goes straight to LOG.
    start_s = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      step();
      start_s = 1'b0;
      $display("small cyc %0d ctrl=%0b log=%0b rdy=%0b", cyc, ctrl_s, log_s, ready_s);
      check_val($sformatf("s_ctrl_%0d", cyc), ctrl_s, (cyc <= 2));
      check_val($sformatf("s_log_%0d", cyc), log_s, (cyc == 4));
      check_val($sformatf("s_rdy_%0d", cyc), ready_s, (cyc == 5));
      check_val($sformatf("s_bidx_%0d", cyc), bidx_s, 1'b0);
    end
    ack_s = 1'b1;
    step();
    ack_s = 1'b0;
    check_val("s_fd", fd_s, 1'b1);
    check_val("s_busy", busy_s, 1'b0);
    check_val("s_rdy_after", ready_s, 1'b0);
    step();
    check_val("s_fd_pulse", fd_s, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
